// File: rtl/ooo_types.sv
// Shared out-of-order core types: register file geometry and free-list sizing.
package ooo_types;

    localparam int unsigned NUM_PHYS_REGS   = 128;
    localparam int unsigned NUM_ARCH_REGS   = 32;
    localparam int unsigned PHYS_REG_BITS   = 7;
    localparam int unsigned FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;

    typedef logic [PHYS_REG_BITS-1:0] phys_tag_t;
    typedef logic [6:0]               fl_ptr_t;
    typedef logic [6:0]               fl_count_t;

    localparam fl_ptr_t   FL_LAST_PTR  = fl_ptr_t'(FREE_LIST_DEPTH - 1);
    localparam fl_count_t FL_DEPTH_CNT = fl_count_t'(FREE_LIST_DEPTH);

endpackage

// File: rtl/free_list_if.sv
// Rename/commit-side handshake to the physical register free list.
interface free_list_if;
    import ooo_types::*;

    logic      alloc_req;
    logic      alloc_valid;
    phys_tag_t alloc_phys;
    logic      free_en;
    phys_tag_t free_phys;
    logic      checkpoint_en;
    logic      restore_en;
    fl_count_t free_count;
    logic      overflow_err;

    modport master (
        output alloc_req, free_en, free_phys, checkpoint_en, restore_en,
        input  alloc_valid, alloc_phys, free_count, overflow_err
    );

    modport slave (
        input  alloc_req, free_en, free_phys, checkpoint_en, restore_en,
        output alloc_valid, alloc_phys, free_count, overflow_err
    );

endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags with single-level branch checkpoint.
module free_list
    import ooo_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    free_list_if.slave  fl
);

    phys_tag_t mem_q [FREE_LIST_DEPTH];
    fl_ptr_t   head_q, tail_q, ckpt_q;
    fl_count_t count_q;
    logic      ovf_q;

    fl_ptr_t   head_d, tail_d, head_after_pop;
    fl_count_t count_d, rewind, base_count;
    logic      pop, push_req, push_ok, ovf_set;

    // Depth is 96, so wrap must be an explicit compare rather than bit truncation.
    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
        if (p == FL_LAST_PTR) begin
            return '0;
        end
        return p + fl_ptr_t'(1);
    endfunction

    function automatic fl_count_t ptr_dist(input fl_ptr_t from, input fl_ptr_t to);
        if (from >= to) begin
            return fl_count_t'(from - to);
        end
        return fl_count_t'(from + FL_DEPTH_CNT - to);
    endfunction

    always_comb begin
        pop            = fl.alloc_req && (count_q != '0) && !fl.restore_en;
        push_req       = fl.free_en && (fl.free_phys != '0);
        rewind         = fl.restore_en ? ptr_dist(head_q, ckpt_q) : '0;
        base_count     = count_q + rewind;
        push_ok        = push_req && ((base_count < FL_DEPTH_CNT) || pop);
        ovf_set        = push_req && !push_ok;
        head_after_pop = pop ? ptr_inc(head_q) : head_q;
        head_d         = fl.restore_en ? ckpt_q : head_after_pop;
        tail_d         = push_ok ? ptr_inc(tail_q) : tail_q;
        count_d        = base_count;
        unique case ({push_ok, pop})
            2'b10:   count_d = base_count + fl_count_t'(1);
            2'b01:   count_d = base_count - fl_count_t'(1);
            default: count_d = base_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            ckpt_q  <= '0;
            count_q <= FL_DEPTH_CNT;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            // Snapshot includes this cycle's pop so the branch keeps its own tag.
            if (fl.checkpoint_en && !fl.restore_en) begin
                ckpt_q <= head_after_pop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FREE_LIST_DEPTH); i++) begin
                mem_q[i] <= phys_tag_t'(int'(NUM_ARCH_REGS) + i);
            end
        end else if (push_ok) begin
            mem_q[tail_q] <= fl.free_phys;
        end
    end

    assign fl.alloc_valid  = (count_q != '0);
    assign fl.alloc_phys   = mem_q[head_q];
    assign fl.free_count   = count_q;
    assign fl.overflow_err = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// Scoreboarded directed bench for free_list: expected alloc tags queued by stimulus.
module tb_free_list;
    import ooo_types::*;

    logic clk;
    logic rst_n;

    free_list_if fl_if ();

    free_list u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_pass   = 0;
    phys_tag_t exp_q[$];
    phys_tag_t mon_exp;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fl_if.alloc_req     = 1'b0;
        fl_if.free_en       = 1'b0;
        fl_if.free_phys     = '0;
        fl_if.checkpoint_en = 1'b0;
        fl_if.restore_en    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every accepted pop must present the next queued tag.
    always @(negedge clk) begin
        if (rst_n && fl_if.alloc_req && fl_if.alloc_valid && !fl_if.restore_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL alloc_unexpected: got %0d expected no pop", fl_if.alloc_phys);
            end else begin
                mon_exp = exp_q.pop_front();
                check("alloc_phys", int'(fl_if.alloc_phys), int'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_count", int'(fl_if.free_count), 96);
        check("rst_valid", int'(fl_if.alloc_valid), 1);
        check("rst_phys", int'(fl_if.alloc_phys), 32);
        check("rst_ovf", int'(fl_if.overflow_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Three pops in order from reset.
        fl_if.alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(phys_tag_t'(32 + i));
            step();
        end
        fl_if.alloc_req = 1'b0;
        check("count_after3", int'(fl_if.free_count), 93);

        // Return p1, then drain; head wraps 95 -> 0 and p1 comes out last.
        fl_if.free_en   = 1'b1;
        fl_if.free_phys = 7'd1;
        step();
        clear_inputs();
        check("count_after_free1", int'(fl_if.free_count), 94);
        fl_if.alloc_req = 1'b1;
        for (int i = 0; i < 93; i++) begin
            exp_q.push_back(phys_tag_t'(35 + i));
            step();
        end
        exp_q.push_back(7'd1);
        step();
        fl_if.alloc_req = 1'b0;
        check("empty_count", int'(fl_if.free_count), 0);
        check("empty_valid", int'(fl_if.alloc_valid), 0);
        fl_if.alloc_req = 1'b1;
        step();
        fl_if.alloc_req = 1'b0;
        check("empty_pop_count", int'(fl_if.free_count), 0);
        check("empty_pop_valid", int'(fl_if.alloc_valid), 0);

        // Pop+push at empty: no bypass, push lands.
        fl_if.alloc_req = 1'b1;
        fl_if.free_en   = 1'b1;
        fl_if.free_phys = 7'd9;
        step();
        clear_inputs();
        check("empty_pushpop_count", int'(fl_if.free_count), 1);
        check("empty_pushpop_phys", int'(fl_if.alloc_phys), 9);

        // Full boundary: pop+push legal, lone push overflows, p0 ignored.
        do_reset();
        check("rst2_count", int'(fl_if.free_count), 96);
        fl_if.alloc_req = 1'b1;
        fl_if.free_en   = 1'b1;
        fl_if.free_phys = 7'd7;
        exp_q.push_back(7'd32);
        step();
        clear_inputs();
        check("full_pushpop_count", int'(fl_if.free_count), 96);
        check("full_pushpop_ovf", int'(fl_if.overflow_err), 0);
        fl_if.free_en   = 1'b1;
        fl_if.free_phys = 7'd5;
        step();
        clear_inputs();
        check("ovf_set", int'(fl_if.overflow_err), 1);
        check("ovf_count", int'(fl_if.free_count), 96);
        check("ovf_phys", int'(fl_if.alloc_phys), 33);
        fl_if.alloc_req = 1'b1;
        exp_q.push_back(7'd33);
        step();
        fl_if.alloc_req = 1'b0;
        check("count_95", int'(fl_if.free_count), 95);
        fl_if.free_en   = 1'b1;
        fl_if.free_phys = 7'd0;
        step();
        clear_inputs();
        check("p0_ignored", int'(fl_if.free_count), 95);
        check("ovf_sticky", int'(fl_if.overflow_err), 1);

        // Checkpoint with pop, two more pops, restore.
        do_reset();
        fl_if.alloc_req = 1'b1;
        exp_q.push_back(7'd32);
        step();
        exp_q.push_back(7'd33);
        step();
        fl_if.checkpoint_en = 1'b1;
        exp_q.push_back(7'd34);
        step();
        fl_if.checkpoint_en = 1'b0;
        exp_q.push_back(7'd35);
        step();
        exp_q.push_back(7'd36);
        step();
        fl_if.alloc_req = 1'b0;
        check("pre_restore_count", int'(fl_if.free_count), 91);
        fl_if.restore_en = 1'b1;
        step();
        clear_inputs();
        check("restore_count", int'(fl_if.free_count), 93);
        check("restore_phys", int'(fl_if.alloc_phys), 35);
        fl_if.alloc_req = 1'b1;
        exp_q.push_back(7'd35);
        step();
        exp_q.push_back(7'd36);
        step();
        fl_if.alloc_req = 1'b0;
        check("pre_restore2_count", int'(fl_if.free_count), 91);

        // Restore beats alloc; push in same cycle still honoured.
        fl_if.restore_en = 1'b1;
        fl_if.alloc_req  = 1'b1;
        fl_if.free_en    = 1'b1;
        fl_if.free_phys  = 7'd40;
        step();
        clear_inputs();
        check("restore_push_count", int'(fl_if.free_count), 94);
        check("restore_push_phys", int'(fl_if.alloc_phys), 35);
        fl_if.alloc_req = 1'b1;
        exp_q.push_back(7'd35);
        step();
        exp_q.push_back(7'd36);
        step();
        check("pre_async_count", int'(fl_if.free_count), 92);

        // Async reset mid-cycle while alloc_req is held.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count", int'(fl_if.free_count), 96);
        check("async_phys", int'(fl_if.alloc_phys), 32);
        check("async_valid", int'(fl_if.alloc_valid), 1);
        check("async_ovf", int'(fl_if.overflow_err), 0);
        fl_if.alloc_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
